// File: rtl/regc_writer.sv
// regc_writer: writes words into Register C, waits out its two-stage pipeline, then verifies both readback ports.
module regc_writer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     load_c,
  output logic [DATA_WIDTH-1:0]    data_in_c,
  input  logic [DATA_WIDTH-1:0]    data_out_c1,
  input  logic [DATA_WIDTH-1:0]    data_out_c2,
  input  logic                     err_clr,
  output logic                     done,
  output logic                     mismatch,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, CHECK} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] hold;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_nx;
      if (in_valid && in_ready) hold <= in_data;
    end
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = in_valid ? LOAD : IDLE;
      LOAD:    state_nx = WAIT;
      WAIT:    state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign load_c    = state == LOAD;
  assign done      = state == CHECK;
  assign data_in_c = hold;
  assign mismatch  = done && (data_out_c1 != hold || data_out_c2 != hold);
  // Clear takes priority over a coincident mismatch; the count saturates at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_count <= '0;
    else if (err_clr) err_count <= '0;
    else if (mismatch && err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_regc_writer.sv
// tb_regc_writer: randomized bench with a Register C pipeline model and a transaction-level expectation model.
module tb_regc_writer;
  logic        clk = 0, reset = 0, in_valid = 0, err_clr = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, load_c, done, mismatch, busy;
  logic [31:0] data_in_c, data_out_c1, data_out_c2;
  logic [7:0]  err_count;
  logic        in_ready2, load_c2, done2, mismatch2, busy2;
  logic [31:0] data_in_c2;
  logic [1:0]  err_count2;
  logic [31:0] r1 = 0, r2 = 0, m1 = 0, m2 = 0;
  int checks = 0, errors = 0, cyc = 0, exp_err = 0, exp_err2 = 0;

  regc_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .load_c(load_c), .data_in_c(data_in_c), .data_out_c1(data_out_c1), .data_out_c2(data_out_c2),
    .err_clr(err_clr), .done(done), .mismatch(mismatch), .busy(busy), .err_count(err_count)
  );
  regc_writer #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .load_c(load_c2), .data_in_c(data_in_c2), .data_out_c1(data_out_c1), .data_out_c2(data_out_c2),
    .err_clr(err_clr), .done(done2), .mismatch(mismatch2), .busy(busy2), .err_count(err_count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Register C: two pipeline stages, with per-port corruption masks to force mismatches.
  always @(posedge clk) begin
    if (load_c) r1 <= data_in_c;
    r2 <= r1;
  end
  assign data_out_c1 = r2 ^ m1;
  assign data_out_c2 = r2 ^ m2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_load"}, load_c, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mm"}, mismatch, 0);
  endtask

  // Entered and left at a falling edge; the word is offered in the first cycle.
  task automatic word(input logic [31:0] d, input logic [31:0] x1, input logic [31:0] x2,
                      input bit clr, input bit hold_valid, output int acc);
    bit mm;
    mm = (x1 | x2) != 0;
    in_valid = 1; in_data = d; m1 = x1; m2 = x2;
    acc = cyc;
    chk("acc_ready", in_ready, 1);
    chk("acc_busy", busy, 0);
    @(negedge clk);
    in_valid = hold_valid; in_data = $urandom;
    chk("c1_load", load_c, 1);
    chk("c1_busy", busy, 1);
    chk("c1_ready", in_ready, 0);
    chk("c1_done", done, 0);
    chk("c1_data", data_in_c, d);
    @(negedge clk);
    in_data = $urandom;
    chk("c2_load", load_c, 0);
    chk("c2_ready", in_ready, 0);
    chk("c2_done", done, 0);
    chk("c2_mm", mismatch, 0);
    @(negedge clk);
    chk("c3_done", done, 1);
    chk("c3_mm", mismatch, mm);
    chk("c3_ready", in_ready, 0);
    chk("c3_data", data_in_c, d);
    chk("c3_done2", done2, 1);
    chk("c3_mm2", mismatch2, mm);
    err_clr = clr; in_data = $urandom;
    @(negedge clk);
    err_clr = 0; m1 = 0; m2 = 0;
    exp_err  = clr ? 0 : (mm ? (exp_err  + 1 > 255 ? 255 : exp_err  + 1) : exp_err);
    exp_err2 = clr ? 0 : (mm ? (exp_err2 + 1 > 3   ? 3   : exp_err2 + 1) : exp_err2);
    chk("c4_err", err_count, exp_err);
    chk("c4_err2", err_count2, exp_err2);
    chk("c4_busy", busy, 0);
    chk("c4_ready", in_ready, 1);
    chk("c4_done", done, 0);
    chk("c4_hold", data_in_c, d);
  endtask

  initial begin
    int a0, a1, a2;
    in_valid = 1; in_data = 32'hAAAA_5555;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_in_c, 0);
    chk("rst_err", err_count, 0);
    reset = 1; in_valid = 0;
    @(negedge clk);
    idle_check("post_rst");
    chk("post_rst_data", data_in_c, 0);

    word(32'hDEADBEEF, 0, 0, 0, 0, a0);
    chk("first_err", err_count, 0);

    word(32'h1, 0, 0, 0, 1, a0);
    word(32'hFFFFFFFF, 0, 0, 0, 1, a1);
    word(32'h0, 0, 0, 0, 0, a2);
    chk("b2b_gap1", a1 - a0, 4);
    chk("b2b_gap2", a2 - a1, 4);

    word(32'h12345679, 0, 32'h1, 0, 0, a0);
    chk("mm_err1", err_count, 1);

    err_clr = 1; @(negedge clk); err_clr = 0;
    exp_err = 0; exp_err2 = 0;
    chk("clr_err", err_count, 0);
    chk("clr_err2", err_count2, 0);
    for (int i = 0; i < 5; i++) begin
      word($urandom, 32'h1 << (i * 5), 0, 0, 0, a0);
      chk("sat_seq", err_count2, (i < 3) ? i + 1 : 3);
    end
    err_clr = 1; @(negedge clk); err_clr = 0;
    exp_err = 0; exp_err2 = 0;
    chk("sat_clr", err_count2, 0);

    word(32'hCAFEF00D, 32'h8000_0000, 0, 0, 0, a0);
    word(32'h0BADF00D, 0, 32'h10, 1, 0, a0);
    chk("clr_wins", err_count, 0);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        in_valid = 0; in_data = $urandom;
        @(negedge clk);
        idle_check("gap");
      end
      word($urandom,
           ($urandom % 4 == 0) ? 32'h1 << $urandom_range(0, 31) : 32'h0,
           ($urandom % 4 == 0) ? 32'h1 << $urandom_range(0, 31) : 32'h0,
           ($urandom % 6 == 0), 0, a0);
    end

    word(32'h5A5A5A5A, 0, 32'h4, 0, 0, a0);
    in_valid = 1; in_data = 32'h13572468;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("wait_busy", busy, 1);
    reset = 0;
    #1;
    exp_err = 0; exp_err2 = 0;
    idle_check("abort");
    chk("abort_err", err_count, 0);
    chk("abort_data", data_in_c, 0);
    @(negedge clk);
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      idle_check("after_abort");
    end
    word(32'h2468ACE0, 0, 0, 0, 0, a0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/regc_writer.md
# regc_writer

Write-side controller for the Register C block. Accepts words from an upstream valid/ready source and drives `load_c`/`data_in_c` into Register C, which has a two-stage output pipeline. It waits out that pipeline latency, then reads back both Register C output ports and compares them against the word written. It reports completion, mismatches and a saturating error count to the sequencer.

## Interface
- `DATA_WIDTH`, 32, width of data words; must match Register C.
- `ERR_CNT_WIDTH`, 8, width of the saturating mismatch counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  DATA_WIDTH  upstream word.
- `load_c`  out  1  load strobe to Register C.
- `data_in_c`  out  DATA_WIDTH  write data to Register C.
- `data_out_c1`  in  DATA_WIDTH  Register C output port 1 (readback).
- `data_out_c2`  in  DATA_WIDTH  Register C output port 2 (readback).
- `err_clr`  in  1  synchronous clear of `err_count`.
- `done`  out  1  one-cycle pulse: write committed and checked.
- `mismatch`  out  1  one-cycle pulse, coincident with `done`: readback differed.
- `busy`  out  1  a write is in progress (state is not IDLE).
- `err_count`  out  ERR_CNT_WIDTH  number of mismatches, saturating.

## Operation
FSM states are IDLE, LOAD, WAIT and CHECK.
- IDLE: `in_ready`=1.
  - On `in_valid`&&`in_ready`, capture `in_data` into the hold register and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `load_c`=1 for exactly this cycle. Go to WAIT.
- WAIT: `load_c`=0. Go to CHECK. This state covers Register C's second pipeline stage.
- CHECK: compare the hold register with `data_out_c1` and with `data_out_c2`.
  - Pulse `done`=1.
  - `mismatch`=1 if either port differs.
  - Go to IDLE.
- `data_in_c` always equals the hold register. It is stable for the whole transaction and holds its value after the transaction.
- `in_ready` = (state==IDLE). `busy` = (state!=IDLE).
- `err_count` increments by 1 on each `mismatch`. It saturates at 2^ERR_CNT_WIDTH−1 and never wraps.
- `err_clr` sets `err_count` to 0 on the next edge. When `err_clr` and `mismatch` occur in the same cycle, the clear wins: count becomes 0, but `mismatch` still pulses.
- `in_valid` and `in_data` are ignored outside IDLE. Upstream must hold them until `in_ready`.
- Compare width is the full DATA_WIDTH, with no masking.

## Timing
- Reset (`reset`=0, asynchronous):
  - State = IDLE.
  - Hold register = 0, so `data_in_c`=0.
  - `load_c`=0, `done`=0, `mismatch`=0, `busy`=0, `err_count`=0.
  - `in_ready`=1, but handshakes are not taken while reset is asserted.
- Reset mid-transaction: the FSM aborts to IDLE immediately. No `done` or `mismatch` pulse is produced for the aborted word, and `err_count` is cleared.
- Handshake accepted at edge E0 (end of cycle 0):
  - LOAD in cycle 1, with `load_c`=1. Register C samples it at edge E1.
  - WAIT in cycle 2.
  - CHECK in cycle 3: `data_out_c1` and `data_out_c2` must already show the new word, having passed both pipeline stages by E2. `done` is high in cycle 3.
  - IDLE in cycle 4, with `in_ready`=1 again.
- Throughput is one word per 4 cycles. Latency from handshake to `done` is 3 cycles.
- A back-to-back word offered continuously is accepted at the end of cycle 4.
- `load_c`, `done` and `mismatch` are decoded from the registered state, are glitch-free, and are each exactly one cycle wide.

## Test plan
- Reset release, then one word 0xDEADBEEF:
  - `load_c` is high exactly 1 cycle later.
  - `done`=1 three cycles after the handshake.
  - `mismatch`=0 and `err_count`=0.
- Three words 0x1, 0xFFFFFFFF, 0x0 with `in_valid` held high:
  - Accepted at cycles 0, 4 and 8.
  - Three `done` pulses.
  - `in_ready` is low in every non-IDLE cycle.
- Readback model forces `data_out_c2`=0x12345678 while 0x12345679 is written:
  - `done`=1 and `mismatch`=1 in the same cycle.
  - `err_count` goes to 1.
- With ERR_CNT_WIDTH=2, 5 forced mismatches:
  - `err_count` sequence is 1, 2, 3, 3, 3.
  - Then `err_clr` gives 0.
- `err_clr` asserted in the CHECK cycle of a mismatching write: `mismatch`=1 and `err_count` ends at 0.
- `reset` pulsed low during WAIT:
  - No `done` pulse follows.
  - All outputs return to their reset values immediately.
  - The next word completes normally.
